mem_loader: RTL

//  Bus master upstream of memory: takes a byte stream from a host (debug/boot link) and writes it

---
 rtl/mem_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// Byte-stream memory loader: receives {address, length, data...} packets from a host link
// and writes the data bytes into RAM, holding the CPU off the bus while a packet is in flight.
// Bytes aimed below RAM_BASE or at/above IO_BASE are skipped and flagged in err_prot.
// Optional feature: define MEM_LOADER_VERIFY_EN to read back and compare each stored byte.
module mem_loader #(
   parameter logic [7:0] RAM_BASE = 8'h80,
   parameter logic [7:0] IO_BASE  = 8'hE0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] mem_address,
   output logic [7:0] mem_data_in,
   output logic       mem_write,
   input  logic [7:0] mem_data_out,
   output logic       cpu_hold,
   output logic       done,
   output logic       err_prot,
   output logic       err_verify,
   output logic [7:0] byte_count
);

   typedef enum logic [2:0] {StIdle, StLen, StData, StWr, StVrd, StVcmp, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic [7:0] addr_q, addr_d;
   logic       prot_q, prot_d;
   logic       accept;
   logic       in_range;
   logic       last_byte;

`ifdef MEM_LOADER_VERIFY_EN
   logic       ver_q, ver_d;
`endif

   assign in_range  = (ptr_q >= RAM_BASE) && (ptr_q < IO_BASE);
   assign last_byte = (cnt_q == len_q);

   // Next-state and output decode for the packet FSM.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
      accept    = 1'b0;
      mem_write = 1'b0;
      cpu_hold  = 1'b0;
      done      = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
      ver_d     = ver_q;
`endif
      unique case (state_q)
         StIdle: begin
            accept = 1'b1;
            if (in_valid) begin
               ptr_d   = in_data;
               cnt_d   = 8'd0;
               prot_d  = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
               ver_d   = 1'b0;
`endif
               state_d = StLen;
            end
         end
         StLen: begin
            accept   = 1'b1;
            cpu_hold = 1'b1;
            if (in_valid) begin
               len_d   = in_data;
               state_d = (in_data == 8'd0) ? StDone : StData;
            end
         end
         StData: begin
            accept   = 1'b1;
            cpu_hold = 1'b1;
            if (in_valid) begin
               data_d  = in_data;
               cnt_d   = cnt_q + 8'd1;
               state_d = StWr;
            end
         end
         StWr: begin
            cpu_hold  = 1'b1;
            mem_write = in_range;
            addr_d    = ptr_q;
            ptr_d     = ptr_q + 8'd1;
            if (!in_range) prot_d = 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
            if (in_range)       state_d = StVrd;
            else if (last_byte) state_d = StDone;
            else                state_d = StData;
`else
            state_d = last_byte ? StDone : StData;
`endif
         end
`ifdef MEM_LOADER_VERIFY_EN
         // addr_q already holds the just-written address (ptr-1).
         StVrd: begin
            cpu_hold = 1'b1;
            state_d  = StVcmp;
         end
         StVcmp: begin
            cpu_hold = 1'b1;
            if (mem_data_out != data_q) ver_d = 1'b1;
            state_d = last_byte ? StDone : StData;
         end
`endif
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Host handshake is blocked while reset is held.
   assign in_ready    = accept & ~reset;
   // The write address is presented directly in WR and held afterwards.
   assign mem_address = (state_q == StWr) ? ptr_q : addr_q;
   assign mem_data_in = data_q;
   assign byte_count  = cnt_q;
   assign err_prot    = prot_q;

`ifdef MEM_LOADER_VERIFY_EN
   assign err_verify = ver_q;

   // Sticky readback-mismatch flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ver_q <= 1'b0;
      else       ver_q <= ver_d;
   end
`else
   logic unused_mem_data;
   assign unused_mem_data = ^mem_data_out;
   assign err_verify      = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= 8'd0;
         len_q   <= 8'd0;
         cnt_q   <= 8'd0;
         data_q  <= 8'd0;
         addr_q  <= 8'd0;
         prot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         prot_q  <= prot_d;
      end
   end

endmodule
